// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 decrypt core: FSM state encoding,
// S-box size, plaintext character class and MSB-first key byte selection.
package rc4_pkg;

    localparam int S_SIZE        = 256;
    localparam int KEY_MAX_BYTES = 32;

    typedef enum logic [4:0] {
        IDLE,
        INIT,
        K_RD_I, K_CAP_I, K_RD_J, K_CAP_J, K_WR_I, K_WR_J,
        P_INC, P_RD_I, P_CAP_I, P_RD_J, P_CAP_J, P_WR_I, P_WR_J,
        P_RD_F, P_CAP_F, P_OUT,
        DONE
    } state_t;

    function automatic logic is_text_char(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
    endfunction

    // Byte 0 is the most significant byte of a key nbytes long.
    function automatic logic [7:0] key_byte(input logic [8*KEY_MAX_BYTES-1:0] key,
                                            input int unsigned nbytes,
                                            input int unsigned idx);
        return key[8*(nbytes-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/rc4_decrypt_core.sv
// RC4 key schedule + PRGA over an encrypted ROM, writing plaintext to a result
// RAM and flagging whether every decrypted byte is lowercase text or space.
module rc4_decrypt_core
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES   = 3,
    parameter int unsigned MSG_LEN     = 32,
    parameter int unsigned EARLY_ABORT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wen,
    input  logic [7:0]             s_rdata,
    output logic [7:0]             msg_addr,
    input  logic [7:0]             msg_rdata,
    output logic [7:0]             out_addr,
    output logic [7:0]             out_wdata,
    output logic                   out_wen,
    output logic                   busy,
    output logic                   done,
    output logic                   text_ok
);

    localparam int          KEY_EXT_W = 8 * KEY_MAX_BYTES;
    localparam logic [7:0]  I_LAST    = 8'(S_SIZE - 1);
    localparam logic [7:0]  K_LAST    = 8'(MSG_LEN - 1);

    state_t     state, state_nx;
    logic [7:0] i, j, k, si, sj, f, m;
    logic [7:0] i_nx, j_nx, k_nx, si_nx, sj_nx, f_nx, m_nx;
    logic       ok_nx;
    logic [7:0] s_addr_nx, s_wdata_nx, msg_addr_nx, out_addr_nx, out_wdata_nx;
    logic       s_wen_nx, out_wen_nx, busy_nx, done_nx;
    logic [KEY_EXT_W-1:0] key_ext;
    logic [7:0] kb, plain;
    logic       plain_ok;

    assign key_ext  = KEY_EXT_W'(key);
    assign kb       = key_byte(key_ext, KEY_BYTES, 32'(i) % KEY_BYTES);
    assign plain    = f ^ m;
    assign plain_ok = is_text_char(plain);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            f         <= '0;
            m         <= '0;
            text_ok   <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wen     <= 1'b0;
            msg_addr  <= '0;
            out_addr  <= '0;
            out_wdata <= '0;
            out_wen   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            i         <= i_nx;
            j         <= j_nx;
            k         <= k_nx;
            si        <= si_nx;
            sj        <= sj_nx;
            f         <= f_nx;
            m         <= m_nx;
            text_ok   <= ok_nx;
            s_addr    <= s_addr_nx;
            s_wdata   <= s_wdata_nx;
            s_wen     <= s_wen_nx;
            msg_addr  <= msg_addr_nx;
            out_addr  <= out_addr_nx;
            out_wdata <= out_wdata_nx;
            out_wen   <= out_wen_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        i_nx     = i;
        j_nx     = j;
        k_nx     = k;
        si_nx    = si;
        sj_nx    = sj;
        f_nx     = f;
        m_nx     = m;
        ok_nx    = text_ok;
        case (state)
            IDLE: if (start) begin
                state_nx = INIT;
                i_nx     = '0;
                j_nx     = '0;
                k_nx     = '0;
                ok_nx    = 1'b0;
            end
            INIT: begin
                i_nx = i + 8'd1;
                if (i == I_LAST) state_nx = K_RD_I;
            end
            K_RD_I:  state_nx = K_CAP_I;
            K_CAP_I: begin
                si_nx    = s_rdata;
                j_nx     = j + s_rdata + kb;
                state_nx = K_RD_J;
            end
            K_RD_J:  state_nx = K_CAP_J;
            K_CAP_J: begin
                sj_nx    = s_rdata;
                state_nx = K_WR_I;
            end
            K_WR_I:  state_nx = K_WR_J;
            K_WR_J: begin
                i_nx     = i + 8'd1;
                state_nx = K_RD_I;
                if (i == I_LAST) begin
                    j_nx     = '0;
                    ok_nx    = 1'b1;
                    state_nx = P_INC;
                end
            end
            P_INC: begin
                i_nx     = i + 8'd1;
                state_nx = P_RD_I;
            end
            P_RD_I:  state_nx = P_CAP_I;
            P_CAP_I: begin
                si_nx    = s_rdata;
                j_nx     = j + s_rdata;
                state_nx = P_RD_J;
            end
            P_RD_J:  state_nx = P_CAP_J;
            P_CAP_J: begin
                sj_nx    = s_rdata;
                state_nx = P_WR_I;
            end
            P_WR_I:  state_nx = P_WR_J;
            P_WR_J:  state_nx = P_RD_F;
            P_RD_F:  state_nx = P_CAP_F;
            P_CAP_F: begin
                f_nx     = s_rdata;
                m_nx     = msg_rdata;
                state_nx = P_OUT;
            end
            P_OUT: begin
                k_nx     = k + 8'd1;
                state_nx = P_INC;
                if (!plain_ok) ok_nx = 1'b0;
                if ((k == K_LAST) || ((EARLY_ABORT != 0) && !plain_ok)) state_nx = DONE;
            end
            DONE:    if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Memory-side outputs belong to the state being entered, so they are
        // registered in step with the state and appear during that state.
        s_addr_nx    = '0;
        s_wdata_nx   = '0;
        s_wen_nx     = 1'b0;
        msg_addr_nx  = '0;
        out_addr_nx  = '0;
        out_wdata_nx = '0;
        out_wen_nx   = 1'b0;
        case (state_nx)
            INIT: begin
                s_addr_nx  = i_nx;
                s_wdata_nx = i_nx;
                s_wen_nx   = 1'b1;
            end
            K_RD_I, P_RD_I: s_addr_nx = i_nx;
            K_RD_J, P_RD_J: s_addr_nx = j_nx;
            K_WR_I, P_WR_I: begin
                s_addr_nx  = i_nx;
                s_wdata_nx = sj_nx;
                s_wen_nx   = 1'b1;
            end
            K_WR_J, P_WR_J: begin
                s_addr_nx  = j_nx;
                s_wdata_nx = si_nx;
                s_wen_nx   = 1'b1;
            end
            P_RD_F: begin
                s_addr_nx   = si_nx + sj_nx;
                msg_addr_nx = k_nx;
            end
            P_OUT: begin
                out_addr_nx  = k_nx;
                out_wdata_nx = f_nx ^ m_nx;
                out_wen_nx   = 1'b1;
            end
            default: ;
        endcase
        busy_nx = (state_nx != IDLE) && (state_nx != DONE);
        done_nx = (state_nx == DONE);
    end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Directed bench: three cores (3-byte key, 3-byte key with early abort,
// 4-byte key) run in lockstep against behavioural S, ROM and result memories.
module tb_rc4_decrypt_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] key3 = 24'h1E4600;
    logic [31:0] key4 = 32'h01020304;

    logic [7:0] s_addr[3], s_wdata[3], s_rdata[3], msg_addr[3], msg_rdata[3];
    logic [7:0] out_addr[3], out_wdata[3];
    logic       s_wen[3], out_wen[3], busy[3], done[3], text_ok[3];

    logic [7:0] s_mem[3][256];
    logic [7:0] msg_mem[3][256];
    logic [7:0] log_addr[3][512];
    logic [7:0] log_data[3][512];
    logic [8:0] wcnt[3] = '{9'd0, 9'd0, 9'd0};

    logic [7:0] pt[32], pt_ea[32], ks3[32], ks4[32], s4_ksa[256];
    logic [7:0] m_s[256], m_ks[32];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(32), .EARLY_ABORT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key3),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wen(s_wen[0]), .s_rdata(s_rdata[0]),
        .msg_addr(msg_addr[0]), .msg_rdata(msg_rdata[0]),
        .out_addr(out_addr[0]), .out_wdata(out_wdata[0]), .out_wen(out_wen[0]),
        .busy(busy[0]), .done(done[0]), .text_ok(text_ok[0]));

    rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(32), .EARLY_ABORT(1)) dut_ea (
        .clk(clk), .reset(reset), .start(start), .key(key3),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wen(s_wen[1]), .s_rdata(s_rdata[1]),
        .msg_addr(msg_addr[1]), .msg_rdata(msg_rdata[1]),
        .out_addr(out_addr[1]), .out_wdata(out_wdata[1]), .out_wen(out_wen[1]),
        .busy(busy[1]), .done(done[1]), .text_ok(text_ok[1]));

    rc4_decrypt_core #(.KEY_BYTES(4), .MSG_LEN(32), .EARLY_ABORT(0)) dut_k4 (
        .clk(clk), .reset(reset), .start(start), .key(key4),
        .s_addr(s_addr[2]), .s_wdata(s_wdata[2]), .s_wen(s_wen[2]), .s_rdata(s_rdata[2]),
        .msg_addr(msg_addr[2]), .msg_rdata(msg_rdata[2]),
        .out_addr(out_addr[2]), .out_wdata(out_wdata[2]), .out_wen(out_wen[2]),
        .busy(busy[2]), .done(done[2]), .text_ok(text_ok[2]));

    // Synchronous-read memories; result RAM writes are logged in order.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (s_wen[d]) s_mem[d][s_addr[d]] <= s_wdata[d];
            s_rdata[d]   <= s_mem[d][s_addr[d]];
            msg_rdata[d] <= msg_mem[d][msg_addr[d]];
            if (out_wen[d]) begin
                log_addr[d][wcnt[d]] <= out_addr[d];
                log_data[d][wcnt[d]] <= out_wdata[d];
                wcnt[d]              <= wcnt[d] + 9'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference RC4: S after the key schedule and the first 32 keystream bytes.
    task automatic rc4_model(input logic [31:0] kv, input int nb);
        logic [7:0] s[256];
        logic [7:0] i8, j8, t;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j8 = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j8 = j8 + s[n] + kv[8*(nb-1-(n % nb)) +: 8];
            t = s[n]; s[n] = s[j8]; s[j8] = t;
        end
        for (int n = 0; n < 256; n++) m_s[n] = s[n];
        i8 = 8'd0;
        j8 = 8'd0;
        for (int n = 0; n < 32; n++) begin
            i8 = i8 + 8'd1;
            j8 = j8 + s[i8];
            t = s[i8]; s[i8] = s[j8]; s[j8] = t;
            t = s[i8] + s[j8];
            m_ks[n] = s[t];
        end
    endtask

    // Entered #1 after the accepting edge's successor, i.e. in cycle 1.
    task automatic run_check(input string tag);
        int d0 = 0, d1 = 0, d2 = 0;
        logic [8:0] b0, b1, b2;
        b0 = wcnt[0]; b1 = wcnt[1]; b2 = wcnt[2];
        for (int c = 1; c <= 3000; c++) begin
            if (c == 1) check({tag, ":busy_c1"}, busy[0], 1);
            if (c <= 256)
                check({tag, ":init_wr"}, {s_wen[0], s_addr[0], s_wdata[0]}, {1'b1, 8'(c-1), 8'(c-1)});
            if (c == 257) check({tag, ":ksa_rd0"}, {s_wen[0], s_addr[0]}, {1'b0, 8'h00});
            if (c == 1795)
                for (int n = 0; n < 256; n++) check({tag, ":k4_ksa_s"}, s_mem[2][n], s4_ksa[n]);
            check({tag, ":one_wen"}, s_wen[0] & out_wen[0], 0);
            if (done[0] && d0 == 0) begin d0 = c; check({tag, ":busy_at_done"}, busy[0], 0); end
            if (done[1] && d1 == 0) d1 = c;
            if (done[2] && d2 == 0) d2 = c;
            if (d0 != 0 && d1 != 0 && d2 != 0) break;
            @(posedge clk); #1;
        end
        check({tag, ":done_cyc"}, d0, 2113);
        check({tag, ":ea_done_cyc"}, d1, 1853);
        check({tag, ":k4_done_cyc"}, d2, 2113);
        check({tag, ":text_ok"}, text_ok[0], 1);
        check({tag, ":ea_text_ok"}, text_ok[1], 0);
        check({tag, ":k4_text_ok"}, text_ok[2], 1);
        check({tag, ":nwr"}, 32'(wcnt[0] - b0), 32);
        check({tag, ":ea_nwr"}, 32'(wcnt[1] - b1), 6);
        check({tag, ":k4_nwr"}, 32'(wcnt[2] - b2), 32);
        for (int n = 0; n < 32; n++) begin
            check({tag, ":result"}, {log_addr[0][b0+n], log_data[0][b0+n]}, {8'(n), pt[n]});
            check({tag, ":k4_result"}, {log_addr[2][b2+n], log_data[2][b2+n]}, {8'(n), pt[n]});
        end
        for (int n = 0; n < 6; n++)
            check({tag, ":ea_result"}, {log_addr[1][b1+n], log_data[1][b1+n]}, {8'(n), pt_ea[n]});
    endtask

    initial begin
        logic [255:0] pts;
        pts = "the quick brown fox jumps over t";
        for (int n = 0; n < 32; n++) pt[n] = pts[8*(31-n) +: 8];
        pt_ea = pt;
        pt_ea[5] = 8'h41;
        rc4_model({8'h00, key3}, 3);
        ks3 = m_ks;
        rc4_model(key4, 4);
        ks4 = m_ks;
        s4_ksa = m_s;
        for (int n = 0; n < 256; n++) begin
            msg_mem[0][n] = (n < 32) ? pt[n] ^ ks3[n] : 8'h00;
            msg_mem[1][n] = (n < 32) ? pt_ea[n] ^ ks3[n] : 8'h00;
            msg_mem[2][n] = (n < 32) ? pt[n] ^ ks4[n] : 8'h00;
        end

        // Reset held with start high: everything quiet.
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            check("rst_outs", {busy[d], done[d], s_wen[d], out_wen[d], text_ok[d], s_addr[d], out_addr[d]},
                  0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        run_check("run1");

        // Level handshake: done holds while start stays high.
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            check("hold_done", {done[0], busy[0], done[1]}, 3'b101);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("to_idle", {done[0], busy[0], done[1], done[2]}, 0);
        start = 1'b1;
        @(posedge clk); #1;
        run_check("run2");

        // Reset in the middle of the key schedule, then a clean rerun.
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk);
        repeat (899) @(posedge clk);
        #1;
        check("mid_busy", busy[0], 1);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++)
            check("mid_rst_outs",
                  {busy[d], done[d], s_wen[d], out_wen[d], text_ok[d], s_addr[d], s_wdata[d], msg_addr[d]}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        run_check("run3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_decrypt_core.md
Name: rc4_decrypt_core

Overview:
- Parametrised successor to the fixed 24-bit-key arcfour engine.
- Runs the RC4 key schedule over the 256-byte S working memory, then the PRGA over an encrypted message ROM.
- Writes the XOR-decrypted bytes to a result RAM and reports whether the plaintext is valid text (lowercase a–z or space), with optional early abort.
- Sits between the key source (switches or a brute-force key counter) and the three on-chip memories.

Parameters:
- KEY_BYTES, 3: key length in bytes. Byte 0 is the most significant byte of key.
- MSG_LEN, 32: number of message bytes processed. Legal range 1..256.
- EARLY_ABORT, 0: 1 = stop the PRGA at the first invalid plaintext byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- key  in  8*KEY_BYTES  RC4 key.
- s_addr  out  8  S memory address.
- s_wdata  out  8  S memory write data.
- s_wen  out  1  S memory write enable.
- s_rdata  in  8  S memory read data; valid the cycle after the address is driven with s_wen=0.
- msg_addr  out  8  encrypted ROM address.
- msg_rdata  in  8  ROM data; same 1-cycle latency.
- out_addr  out  8  result RAM address.
- out_wdata  out  8  decrypted byte.
- out_wen  out  1  result RAM write enable.
- busy  out  1  high from the first INIT cycle until the DONE state is entered.
- done  out  1  high while in DONE.
- text_ok  out  1  valid while done=1; 1 = every processed byte was valid text.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; i, j, k, si, sj = 0; all outputs 0; text_ok=0. Memories are not cleared. Reset mid-operation aborts immediately; partial memory contents are left as-is.
- Only one memory write enable is high in any cycle. Addresses and wdata are registered outputs.
- IDLE → INIT when start=1. A start that is already high is accepted.
- INIT, 256 cycles: write S[i]=i for i=0..255.
- KSA, 6 cycles per i, i=0..255:
  - K_RD_I: drive s_addr=i.
  - K_CAP_I: si=s_rdata; j=(j+si+key_byte[i mod KEY_BYTES]) mod 256.
  - K_RD_J: drive s_addr=j.
  - K_CAP_J: sj=s_rdata.
  - K_WR_I: write S[i]=sj.
  - K_WR_J: write S[j]=si; i++.
  - After i=255 wraps to 0, reset i and j to 0 and go to PRGA.
- PRGA, 10 cycles per k, k=0..MSG_LEN-1:
  - P_INC: i=i+1.
  - P_RD_I, P_CAP_I: si=S[i]; j=j+si.
  - P_RD_J, P_CAP_J: sj=S[j].
  - P_WR_I: write S[i]=sj.
  - P_WR_J: write S[j]=si.
  - P_RD_F: drive s_addr=(si+sj) mod 256 and msg_addr=k.
  - P_CAP_F: capture f and msg byte.
  - P_OUT: write result[k]=f^msg; update text_ok; k++.
- All index arithmetic is mod 256.
- Text check: text_ok is set to 1 at PRGA entry and cleared on any byte outside 8'h61..8'h7A and not 8'h20.
- Early abort: if EARLY_ABORT=1 and a byte fails the check, the offending byte is still written, then the core enters DONE.
- Latency: the accepting edge is cycle 0. For a full run, done first rises in cycle 256+1536+10·MSG_LEN+1 (2113 for MSG_LEN=32).
- DONE: done=1 and text_ok held. Exit to IDLE on the first cycle start=0. start held high keeps the core in DONE; no auto-restart.
- A new start reinitialises S, i, j, k and text_ok.

Decomposition:
- Shared package rc4_pkg holds:
  - the state enum (IDLE, INIT, K_*, P_*, DONE);
  - S_SIZE=256;
  - function is_text_char(byte);
  - function key_byte(key, idx) for MSB-first byte selection.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 → busy, done, s_wen, out_wen, text_ok all 0. Release reset → busy=1 on the following cycle.
- INIT: key=24'h000001, start=1 → exactly 256 writes S[n]=n in order, addresses 0..255. The first KSA read is at address 0 in cycle 257.
- Full decrypt, KEY_BYTES=3, key=24'h1E4600: ROM holds the software-RC4 encryption of "the quick brown fox jumps over t" (32 bytes) → result RAM equals the plaintext; done rises at cycle 2113; text_ok=1.
- Early abort (EARLY_ABORT=1): plaintext byte 5 = 8'h41 → 6 out_wen pulses (addresses 0..5); done at cycle 256+1536+60+1; text_ok=0.
- Level handshake: start held high after done → done stays 1 for 50 cycles. Drop start → IDLE. Re-raise start → identical result RAM and text_ok.
- Mid-run reset: assert reset at cycle 900 (KSA) → all outputs 0 at the next edge. Restart → result identical to the uninterrupted run.
- KEY_BYTES=4 build: key=32'h01020304 → S after KSA matches the software model byte-for-byte.
